// File: rtl/i2c_txn_trigger.sv
// Pattern-matching trigger for one I2C byte sniffer: matches address, register and a
// masked data byte of a write, waits a programmable delay, then emits a fixed-width strobe.
module i2c_txn_trigger #(
  parameter logic [7:0]  ADDR_BYTE   = 8'h90,
  parameter logic [7:0]  REG_BYTE    = 8'h00,
  parameter logic [7:0]  DATA_VAL    = 8'h00,
  parameter logic [7:0]  DATA_MASK   = 8'hFF,
  parameter bit          REQUIRE_ACK = 1'b1,
  parameter logic [31:0] DELAY       = 32'd0,
  parameter logic [15:0] PULSE_WIDTH = 16'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] byte_in,
  input  logic       byte_ready,
  input  logic       sop,
  input  logic       eot,
  output logic       match,
  output logic       trigger,
  output logic       busy,
  output logic [2:0] state,
  output logic [7:0] fire_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_REG  = 3'd2,
    S_GET_DATA = 3'd3,
    S_SKIP     = 3'd4,
    S_DELAY    = 3'd5,
    S_FIRE     = 3'd6
  } state_t;

  // A zero width would never reach its terminal count, so it is treated as one cycle.
  localparam logic [15:0] PW_EFF   = (PULSE_WIDTH == 16'd0) ? 16'd1 : PULSE_WIDTH;
  localparam logic [31:0] PW_LAST  = {16'd0, PW_EFF} - 32'd1;
  localparam logic [7:0]  DATA_CMP = DATA_VAL & DATA_MASK;

  state_t      state_q, state_d;
  state_t      bus_state;
  logic [31:0] cnt_q, cnt_d;
  logic        match_q, match_d;
  logic [7:0]  fire_count_q, fire_count_d;

  logic [7:0]  byte_data;
  logic        byte_nack;
  logic [7:0]  expected;
  logic [7:0]  observed;
  logic        byte_pass;
  logic        delay_done;
  logic        fire_done;
  logic        listening;

  assign byte_data  = byte_in[8:1];
  assign byte_nack  = byte_in[0];
  assign delay_done = (cnt_q == DELAY);
  assign fire_done  = (cnt_q == PW_LAST);
  assign listening  = (state_q != S_DELAY) && (state_q != S_FIRE);

  // A START is applied before any byte in the same cycle, so that byte is the address.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    bus_state = state_q;
    if (sop && listening) begin
      bus_state = enable ? S_GET_ADDR : S_IDLE;
    end
  end

  always_comb begin
    expected = ADDR_BYTE;
    observed = byte_data;
    case (bus_state)
      S_GET_REG:  expected = REG_BYTE;
      S_GET_DATA: begin
        expected = DATA_CMP;
        observed = byte_data & DATA_MASK;
      end
      default:    expected = ADDR_BYTE;
    endcase
    byte_pass = (observed == expected) && (!REQUIRE_ACK || !byte_nack);
  end

  // Next-state logic.
  always_comb begin
    state_d = bus_state;
    case (bus_state)
      S_GET_ADDR, S_GET_REG, S_GET_DATA: begin
        if (byte_ready) begin
          if (!byte_pass) begin
            state_d = S_SKIP;
          end else begin
            case (bus_state)
              S_GET_ADDR: state_d = S_GET_REG;
              S_GET_REG:  state_d = S_GET_DATA;
              default:    state_d = S_DELAY;
            endcase
          end
        end
        // A STOP aborts everything except a match completed in the same cycle.
        if (eot && (state_d != S_DELAY)) begin
          state_d = S_IDLE;
        end
      end
      S_SKIP:  if (eot) state_d = S_IDLE;
      S_DELAY: if (delay_done) state_d = S_FIRE;
      S_FIRE:  if (fire_done) state_d = S_IDLE;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Delay/width counter, match pulse and fire counter.
  always_comb begin
    cnt_d        = '0;
    fire_count_d = fire_count_q;
    match_d      = (state_q != S_DELAY) && (state_d == S_DELAY);
    if ((state_q == S_DELAY) && !delay_done) begin
      cnt_d = cnt_q + 32'd1;
    end
    if (state_q == S_FIRE) begin
      if (fire_done) begin
        fire_count_d = fire_count_q + 8'd1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      match_q      <= 1'b0;
      fire_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      match_q      <= match_d;
      fire_count_q <= fire_count_d;
    end
  end

  // Outputs.
  always_comb begin
    match      = match_q;
    trigger    = (state_q == S_FIRE);
    busy       = (state_q == S_DELAY) || (state_q == S_FIRE);
    state      = state_q;
    fire_count = fire_count_q;
  end

endmodule

// File: doc/i2c_txn_trigger.md
Name: i2c_txn_trigger

Overview:
Sits between the i2c_listen byte sniffers and the glitch-timing logic. It consumes one sniffer's decoded byte stream (9-bit byte, ready, sop, eot) and matches a programmed three-byte write pattern: address byte, register byte, then a masked data byte. On a match it waits a programmable delay and then emits a fixed-width trigger pulse that the PMIC core or DAC stage uses as its glitch strobe.

Parameters:
ADDR_BYTE, 8'h90, expected first byte after START (7-bit address plus R/W bit).
REG_BYTE, 8'h00, expected second byte (register index).
DATA_VAL, 8'h00, expected third byte after masking.
DATA_MASK, 8'hFF, mask ANDed with both the data byte and DATA_VAL before comparing.
REQUIRE_ACK, 1, when 1 every matched byte must have ACK (bit0 == 0).
DELAY, 32'd0, clk cycles from match to trigger start.
PULSE_WIDTH, 16'd4, trigger high time in clk cycles; must be at least 1.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high.
enable  input  1  level; when 0, no new match is started.
byte_in  input  9  decoded byte: [8:1] data, [0] ACK/NACK (1 = NACK).
byte_ready  input  1  one-cycle strobe; byte_in is valid in that cycle.
sop  input  1  one-cycle START/repeated-START strobe.
eot  input  1  one-cycle STOP strobe.
match  output  1  one-cycle pulse when the full pattern matches.
trigger  output  1  glitch strobe, PULSE_WIDTH cycles long.
busy  output  1  high in DELAY or FIRE.
state  output  3  current FSM state, for the debug port.
fire_count  output  8  number of triggers fired; wraps 255 -> 0.

Behaviour:
- Reset, when sampled high at a posedge:
  - state = IDLE; match = 0; trigger = 0; busy = 0; fire_count = 0.
  - Internal delay/width counter cleared.
  - Reset aborts any state, including mid-DELAY or mid-FIRE; trigger drops the next cycle.
- State encoding: IDLE = 0, GET_ADDR = 1, GET_REG = 2, GET_DATA = 3, SKIP = 4, DELAY = 5, FIRE = 6.
- IDLE: sop && enable -> GET_ADDR. Bytes and eot are ignored.
- Byte compare rule (GET_ADDR / GET_REG / GET_DATA):
  - On byte_ready, the byte passes if byte_in[8:1] equals the expected value (masked in GET_DATA) and, when REQUIRE_ACK = 1, byte_in[0] == 0.
  - Pass advances GET_ADDR -> GET_REG -> GET_DATA -> DELAY. Fail -> SKIP.
- SKIP: wait for the end of the transaction. eot -> IDLE; sop && enable -> GET_ADDR.
- sop in GET_ADDR, GET_REG, GET_DATA or SKIP (repeated START): restart at GET_ADDR if enable = 1, else go to IDLE.
- eot in GET_ADDR, GET_REG or GET_DATA with no byte in the same cycle: -> IDLE.
- Simultaneous strobes:
  - sop with byte_ready: apply sop first, then evaluate the byte as the address byte.
  - byte_ready with eot: evaluate the byte first. A completing data-byte match goes to DELAY; otherwise go to IDLE.
- enable falling mid-match: no effect on a match already in progress. enable only gates entry on sop.
- Match timing: a passing data-byte strobe at posedge T gives match = 1 for exactly cycle T+1, with state = DELAY and counter = 0.
- DELAY:
  - The counter increments each cycle.
  - When counter == DELAY: go to FIRE, clear the counter, set trigger = 1.
  - With DELAY = 0, trigger is first high at T+2.
  - In general, trigger is high from T+2+DELAY through T+1+DELAY+PULSE_WIDTH inclusive.
- FIRE:
  - trigger is held high.
  - When the counter reaches PULSE_WIDTH-1: trigger = 0, fire_count += 1, go to IDLE.
- In DELAY and FIRE all bus strobes (sop, eot, byte_ready) are ignored. A new match needs a fresh sop after IDLE is reached.
- busy = (state == DELAY) || (state == FIRE).
- Widths:
  - Counter is 32-bit; DELAY up to 2^32-1 does not overflow.
  - fire_count wraps modulo 256.

Test Plan:
1. Defaults (ADDR 90, REG 00, DATA 00, DELAY 0, PW 4); drive sop, bytes {90,ack}, {00,ack}, {00,ack} with data strobe at cycle T -> match at T+1; trigger high T+2..T+5; fire_count = 1; state back to 0.
2. DELAY = 10, DATA_MASK = F0, DATA_VAL = A0; data byte A7 -> trigger rises at T+12. Repeat with data byte B7 -> state 4 (SKIP), no match, no trigger; eot returns state to 0.
3. REQUIRE_ACK = 1; register byte 00 with bit0 = 1 (NACK) -> SKIP, no match. Repeat with REQUIRE_ACK = 0 -> match.
4. Repeated START: sop, {90}, {00}, then sop in GET_DATA, then full valid pattern -> exactly one match. Also sop coincident with byte {90} -> next byte is treated as the register byte.
5. DELAY = 100; during DELAY drive a complete valid transaction -> ignored, exactly one trigger, fire_count = 1. Assert reset at DELAY+50 -> trigger never rises, all outputs return to reset values.
6. enable = 0 at sop -> stays IDLE, no match. Run 256 valid matches with DELAY 0, PW 1 -> fire_count wraps to 0.
